// File: rtl/timer_pkg.sv
// Shared constants for the interval timer: register map,
// CTRL bit positions and FSM state encoding.
package timer_pkg;

  localparam logic [1:0] REG_CNT_LO = 2'd0;
  localparam logic [1:0] REG_CNT_HI = 2'd1;
  localparam logic [1:0] REG_CTRL   = 2'd2;
  localparam logic [1:0] REG_STATUS = 2'd3;

  localparam int FREERUN = 0;
  localparam int IRQ_EN  = 1;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

endpackage

// File: rtl/interval_timer.sv
// 16-bit down-counting interval timer with reload latch,
// atomic LO/HI counter read and level interrupt.
module interval_timer
  import timer_pkg::*;
#(
  parameter logic [15:0] RESET_LATCH = 16'hFFFF
) (
  input  logic       clk25,
  input  logic       rst,
  input  logic       cpu_clken,
  input  logic       cs,
  input  logic       we,
  input  logic [1:0] addr,
  input  logic [7:0] din,
  output logic [7:0] dout,
  output logic       irq
);

  logic [15:0] r_latch;
  logic [15:0] r_cnt;
  logic [7:0]  r_hi_hold;
  logic [1:0]  r_ctrl;
  logic        r_flag;
  state_t      r_state;
  logic [7:0]  r_dout;

  logic w_wr;
  logic w_rd;
  logic w_uflow;
  logic w_clr;

  assign w_wr    = cs & cpu_clken & we;
  assign w_rd    = cs & cpu_clken & ~we;
  assign w_uflow = cpu_clken & (r_state == RUN)
                 & (r_cnt == 16'd0);
  assign w_clr   = w_wr & (addr == REG_STATUS) & din[0];

  always_ff @(posedge clk25) begin
    if (rst) begin
      r_latch   <= RESET_LATCH;
      r_cnt     <= RESET_LATCH;
      r_hi_hold <= 8'h00;
      r_ctrl    <= 2'b00;
      r_flag    <= 1'b0;
      r_state   <= IDLE;
      r_dout    <= 8'h00;
    end else if (cpu_clken) begin
      if (r_state == RUN) begin
        if (r_cnt == 16'd0) begin
          if (r_ctrl[FREERUN]) r_cnt <= r_latch;
          else r_state <= IDLE;
        end else begin
          r_cnt <= r_cnt - 16'd1;
        end
      end

      // set beats clear; a CNT_HI write below overrides both
      if (w_uflow) r_flag <= 1'b1;
      else if (w_clr) r_flag <= 1'b0;

      if (w_wr) begin
        case (addr)
          REG_CNT_LO: r_latch[7:0] <= din;
          REG_CNT_HI: begin
            r_latch[15:8] <= din;
            r_cnt         <= {din, r_latch[7:0]};
            r_flag        <= 1'b0;
            r_state       <= RUN;
          end
          REG_CTRL:   r_ctrl <= din[1:0];
          REG_STATUS: ;
          default:    ;
        endcase
      end

      if (w_rd) begin
        case (addr)
          REG_CNT_LO: begin
            r_dout    <= r_cnt[7:0];
            r_hi_hold <= r_cnt[15:8];
          end
          REG_CNT_HI: r_dout <= r_hi_hold;
          REG_CTRL:   r_dout <= {6'b0, r_ctrl};
          REG_STATUS: r_dout <= {(r_state == RUN), 6'b0, r_flag};
          default:    r_dout <= 8'h00;
        endcase
      end
    end
  end

  assign dout = r_dout;
  assign irq  = r_flag & r_ctrl[IRQ_EN];

endmodule
